// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   arb_state_e : sequencing states of the arbiter FSM
//   grant_e     : which requester owned the most recent access
//   word_align  : clears the byte-offset bits of an address
package dmem_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCpuBusy,
      StCpuDone,
      StDbgBusy,
      StDbgDone
   } arb_state_e;

   typedef enum logic {
      GrantCpu,
      GrantDbg
   } grant_e;

   localparam int unsigned DefaultTimeout = 16;
   localparam logic [31:0] DefaultErrData = 32'hDEAD_BEEF;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Watchdog counter for one memory access.
//   clock, reset : clock and synchronous active-high reset
//   clear        : restart the count at zero (access granted)
//   enable       : count this cycle (access in flight)
//   terminal     : high during the Limit-th enabled cycle after a clear
module dmem_wait_timer #(
   parameter int unsigned Limit = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int unsigned CntW = $clog2(Limit + 1);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Count is zero in the first busy cycle, so Limit-1 marks the last one allowed.
   assign terminal = (count_q == CntW'(Limit - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-way arbiter and sequencer for the single-ported data memory behind MEM.
//   MemRead/MemWrite/Address/WriteData : CPU request from the MEM stage
//   ReadData, Stall                    : registered load data, pipeline freeze
//   Dbg_*                              : debug/loader request and completion pulse
//   Mem_*                              : handshaked variable-latency memory port
//   Timeout                            : one-cycle pulse when an access is aborted
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT  = DefaultTimeout,
   parameter logic [31:0] ERR_DATA = DefaultErrData
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   input  logic        Dbg_Req,
   input  logic        Dbg_We,
   input  logic [31:0] Dbg_Addr,
   input  logic [31:0] Dbg_WData,
   output logic        Dbg_Ack,
   output logic [31:0] Dbg_RData,
   output logic        Mem_Req,
   output logic        Mem_We,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_WData,
   input  logic [31:0] Mem_RData,
   input  logic        Mem_Ready,
   output logic        Timeout
);

   arb_state_e  state_q, state_d;
   grant_e      last_grant_q, last_grant_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;
   logic        dbg_ack_q, dbg_ack_d;
   logic        timeout_q, timeout_d;

   logic        cpu_pend;
   logic        timer_clear, timer_en, timer_done;
   logic [31:0] access_rdata;

   assign cpu_pend     = MemRead | MemWrite;
   // An aborted read returns the error marker instead of bus data.
   assign access_rdata = Mem_Ready ? Mem_RData : ERR_DATA;

   dmem_wait_timer #(
      .Limit(TIMEOUT)
   ) u_wait_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .terminal(timer_done)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      read_data_d  = read_data_q;
      dbg_rdata_d  = dbg_rdata_q;
      dbg_ack_d    = 1'b0;
      timeout_d    = 1'b0;
      timer_clear  = 1'b0;
      timer_en     = 1'b0;

      case (state_q)
         StIdle: begin
            // On a tie the requester that did not go last wins.
            if (cpu_pend && (!Dbg_Req || last_grant_q == GrantDbg)) begin
               mem_req_d    = 1'b1;
               mem_we_d     = MemWrite;  // read+write together acts as a write
               mem_addr_d   = word_align(Address);
               mem_wdata_d  = WriteData;
               last_grant_d = GrantCpu;
               timer_clear  = 1'b1;
               state_d      = StCpuBusy;
            end else if (Dbg_Req) begin
               mem_req_d    = 1'b1;
               mem_we_d     = Dbg_We;
               mem_addr_d   = word_align(Dbg_Addr);
               mem_wdata_d  = Dbg_WData;
               last_grant_d = GrantDbg;
               timer_clear  = 1'b1;
               state_d      = StDbgBusy;
            end
         end
         StCpuBusy, StDbgBusy: begin
            timer_en = 1'b1;
            if (Mem_Ready || timer_done) begin
               mem_req_d = 1'b0;
               timeout_d = ~Mem_Ready;
               if (state_q == StCpuBusy) begin
                  if (!mem_we_q) read_data_d = access_rdata;
                  state_d = StCpuDone;
               end else begin
                  if (!mem_we_q) dbg_rdata_d = access_rdata;
                  dbg_ack_d = 1'b1;
                  state_d   = StDbgDone;
               end
            end
         end
         StCpuDone, StDbgDone: state_d = StIdle;
         default:              state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= GrantDbg;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         read_data_q  <= '0;
         dbg_rdata_q  <= '0;
         dbg_ack_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         read_data_q  <= read_data_d;
         dbg_rdata_q  <= dbg_rdata_d;
         dbg_ack_q    <= dbg_ack_d;
         timeout_q    <= timeout_d;
      end
   end

   // CPU_DONE is the single cycle in which the pipeline may advance.
   assign Stall     = cpu_pend & (state_q != StCpuDone) & ~reset;
   assign ReadData  = read_data_q;
   assign Dbg_Ack   = dbg_ack_q;
   assign Dbg_RData = dbg_rdata_q;
   assign Mem_Req   = mem_req_q;
   assign Mem_We    = mem_we_q;
   assign Mem_Addr  = mem_addr_q;
   assign Mem_WData = mem_wdata_q;
   assign Timeout   = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected completions,
// a negedge monitor pops and compares whenever the DUT completes an access.
module tb_dmem_arbiter;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          req_cycles;
      int          stall;
      logic        tout;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [31:0] Address, WriteData, ReadData;
   logic        Stall;
   logic        Dbg_Req, Dbg_We, Dbg_Ack;
   logic [31:0] Dbg_Addr, Dbg_WData, Dbg_RData;
   logic        Mem_Req, Mem_We, Mem_Ready, Timeout;
   logic [31:0] Mem_Addr, Mem_WData, Mem_RData;

   exp_t        cpu_q[$];
   exp_t        dbg_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mem [0:15];
   int          wait_cfg = 0;
   bit          never_ready = 0;
   int          wcnt = 0;
   int          req_run = 0;
   int          stall_run = 0;
   logic        prev_req = 1'b0;

   always #5 clock = ~clock;

   dmem_arbiter #(
      .TIMEOUT (16),
      .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .Address  (Address),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .Stall    (Stall),
      .Dbg_Req  (Dbg_Req),
      .Dbg_We   (Dbg_We),
      .Dbg_Addr (Dbg_Addr),
      .Dbg_WData(Dbg_WData),
      .Dbg_Ack  (Dbg_Ack),
      .Dbg_RData(Dbg_RData),
      .Mem_Req  (Mem_Req),
      .Mem_We   (Mem_We),
      .Mem_Addr (Mem_Addr),
      .Mem_WData(Mem_WData),
      .Mem_RData(Mem_RData),
      .Mem_Ready(Mem_Ready),
      .Timeout  (Timeout)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_done(input string who, input exp_t e, input logic [31:0] rdata);
      check32({who, "_mem_addr"}, Mem_Addr, e.addr);
      check32({who, "_mem_we"}, {31'd0, Mem_We}, {31'd0, e.we});
      if (e.we) check32({who, "_mem_wdata"}, Mem_WData, e.wdata);
      check32({who, "_rdata"}, rdata, e.rdata);
      check32({who, "_timeout"}, {31'd0, Timeout}, {31'd0, e.tout});
      check_int({who, "_req_cycles"}, req_run, e.req_cycles);
   endtask

   // Memory model: answers after wait_cfg extra cycles, or never.
   always @(negedge clock) begin
      if (Mem_Req === 1'b1 && !never_ready && !reset) begin
         if (wcnt == wait_cfg) begin
            Mem_Ready = 1'b1;
            Mem_RData = mem[Mem_Addr[5:2]];
            if (Mem_We) mem[Mem_Addr[5:2]] = Mem_WData;
            wcnt = 0;
         end else begin
            Mem_Ready = 1'b0;
            Mem_RData = 32'h0BAD_0BAD;
            wcnt++;
         end
      end else begin
         Mem_Ready = 1'b0;
         Mem_RData = 32'h0BAD_0BAD;
         wcnt = 0;
      end
   end

   // Monitor: pops the matching expectation on every completion.
   always @(negedge clock) begin
      exp_t e;
      bit   cpu_evt;
      bit   dbg_evt;
      if (reset !== 1'b0) begin
         req_run   = 0;
         stall_run = 0;
         prev_req  = 1'b0;
      end else begin
         if (Mem_Req) req_run = prev_req ? req_run + 1 : 1;
         prev_req = Mem_Req;
         if (Stall) stall_run++;
         cpu_evt = (MemRead | MemWrite) && !Stall;
         dbg_evt = Dbg_Ack;
         if (cpu_evt) begin
            if (cpu_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL cpu_unexpected_done: got completion expected none");
            end else begin
               e = cpu_q.pop_front();
               check_done("cpu", e, ReadData);
               check_int("cpu_stall_cycles", stall_run, e.stall);
            end
            stall_run = 0;
         end
         if (dbg_evt) begin
            if (dbg_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL dbg_unexpected_ack: got Dbg_Ack expected none");
            end else begin
               e = dbg_q.pop_front();
               check_done("dbg", e, Dbg_RData);
            end
         end
         if (Timeout && !cpu_evt && !dbg_evt) begin
            checks++; errors++;
            $display("FAIL stray_timeout: got Timeout=1 expected 0 outside completion");
         end
      end
   end

   task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rexp, input int waits,
                         input int req_cyc, input int stall, input logic tout);
      exp_t e;
      bit   done = 0;
      e.we = wr; e.addr = {addr[31:2], 2'b00}; e.wdata = wdata; e.rdata = rexp;
      e.req_cycles = req_cyc; e.stall = stall; e.tout = tout;
      cpu_q.push_back(e);
      wait_cfg = waits;
      MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (!Stall) done = 1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL cpu_wait: got no completion expected one within 200 cycles");
      end
      @(posedge clock);
      #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rexp, input int waits, input int req_cyc);
      exp_t e;
      bit   done = 0;
      e.we = we; e.addr = {addr[31:2], 2'b00}; e.wdata = wdata; e.rdata = rexp;
      e.req_cycles = req_cyc; e.stall = 0; e.tout = 1'b0;
      dbg_q.push_back(e);
      wait_cfg = waits;
      Dbg_Req = 1'b1; Dbg_We = we; Dbg_Addr = addr; Dbg_WData = wdata;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (Dbg_Ack) done = 1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL dbg_wait: got no Dbg_Ack expected one within 200 cycles");
      end
      @(posedge clock);
      #1;
      Dbg_Req = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check32({tag, "_mem_req"}, {31'd0, Mem_Req}, 32'd0);
      check32({tag, "_mem_we"}, {31'd0, Mem_We}, 32'd0);
      check32({tag, "_mem_addr"}, Mem_Addr, 32'd0);
      check32({tag, "_mem_wdata"}, Mem_WData, 32'd0);
      check32({tag, "_read_data"}, ReadData, 32'd0);
      check32({tag, "_dbg_rdata"}, Dbg_RData, 32'd0);
      check32({tag, "_dbg_ack"}, {31'd0, Dbg_Ack}, 32'd0);
      check32({tag, "_timeout"}, {31'd0, Timeout}, 32'd0);
      check32({tag, "_stall"}, {31'd0, Stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish expected finish before 200000");
      $fatal(1, "time limit");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
      reset = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
      Dbg_Req = 1'b0; Dbg_We = 1'b0; Dbg_Addr = '0; Dbg_WData = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_quiet("reset_state");
      @(posedge clock);
      #1;

      // Simultaneous requests out of reset: CPU, DBG, CPU, DBG.
      fork
         begin
            cpu_op(1'b0, 1'b1, 32'hC, 32'hAAAA, 32'h0, 0, 1, 2, 1'b0);
            cpu_op(1'b1, 1'b0, 32'h0, 32'h0, 32'h1000_0000, 0, 1, 5, 1'b0);
         end
         begin
            dbg_op(1'b0, 32'hC, 32'h0, 32'hAAAA, 0, 1);
            dbg_op(1'b1, 32'h10, 32'h5555, 32'hAAAA, 0, 1);
         end
      join

      cpu_op(1'b0, 1'b1, 32'h0, 32'hFFFF, 32'h1000_0000, 0, 1, 2, 1'b0);
      cpu_op(1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_FFFF, 0, 1, 2, 1'b0);
      cpu_op(1'b1, 1'b0, 32'h6, 32'h0, 32'h1000_0001, 3, 4, 5, 1'b0);
      never_ready = 1;
      cpu_op(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, 16, 17, 1'b1);
      never_ready = 0;
      cpu_op(1'b1, 1'b1, 32'h8, 32'h1234, 32'hDEAD_BEEF, 0, 1, 2, 1'b0);
      cpu_op(1'b1, 1'b0, 32'h8, 32'h0, 32'h0000_1234, 0, 1, 2, 1'b0);
      dbg_op(1'b0, 32'h10, 32'h0, 32'h5555, 2, 3);

      // Reset in the middle of a CPU access.
      never_ready = 1;
      MemRead = 1'b1; Address = 32'h14;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_quiet("mid_access_reset");
      @(posedge clock);
      #1;
      reset = 1'b0; MemRead = 1'b0; never_ready = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check32("post_reset_no_event", {30'd0, Timeout, Dbg_Ack}, 32'd0);
      end
      check_int("cpu_queue_drained", cpu_q.size(), 0);
      check_int("dbg_queue_drained", dbg_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
